// File: rtl/census_pkg.sv
// census_pkg: shared FSM encoding and width helpers for the census cost scheduler.
package census_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

    function automatic int pc_width(input int cw);
        return $clog2(cw + 1);
    endfunction

    function automatic int cost_width(input int bw, input int cw);
        return $clog2(bw * cw + 1);
    endfunction

    function automatic int disp_width(input int nd);
        return $clog2(nd);
    endfunction

    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/census_word_popcount.sv
// census_word_popcount: combinational Hamming distance of two census words.
module census_word_popcount
    import census_pkg::*;
#(
    parameter int CENSUS_W = 16,
    localparam int PC_W = pc_width(CENSUS_W)
) (
    input  logic [CENSUS_W-1:0] left,
    input  logic [CENSUS_W-1:0] right,
    output logic [PC_W-1:0]     count
);
    localparam int N = CENSUS_W / 4;
    localparam int L = N > 1 ? $clog2(N) : 0;
    localparam int P = 1 << L;
    logic [CENSUS_W-1:0] x;
    logic [PC_W-1:0] t [2*P-1];
    assign x = left ^ right;
    // Heap-ordered tree: leaves are nibble counts, node i sums children 2i+1 and 2i+2.
    always_comb begin
        for (int i = 0; i < 2*P-1; i++) t[i] = '0;
        for (int i = 0; i < N; i++)
            t[P-1+i] = PC_W'(x[4*i]) + PC_W'(x[4*i+1]) + PC_W'(x[4*i+2]) + PC_W'(x[4*i+3]);
        for (int i = P-2; i >= 0; i--) t[i] = t[2*i+1] + t[2*i+2];
    end
    assign count = t[0];
endmodule

// File: rtl/census_cost_scheduler.sv
// census_cost_scheduler: accumulates per-disparity census block costs and reports the minimum-cost disparity.
module census_cost_scheduler
    import census_pkg::*;
#(
    parameter int CENSUS_W    = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int NUM_DISP    = 16,
    localparam int PC_W   = pc_width(CENSUS_W),
    localparam int COST_W = cost_width(BLOCK_WORDS, CENSUS_W),
    localparam int DISP_W = disp_width(NUM_DISP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CENSUS_W-1:0] in_left,
    input  logic [CENSUS_W-1:0] in_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DISP_W-1:0]   out_disp,
    output logic [COST_W-1:0]   out_cost,
    output logic                busy
);
    localparam int WC_W = cnt_width(BLOCK_WORDS);

    state_t state, state_nx;
    logic [WC_W-1:0] word_cnt;
    logic [DISP_W-1:0] disp_cnt, pc_disp, best_disp;
    logic [PC_W-1:0] pc, pc_reg;
    logic [COST_W-1:0] acc, best_cost, sum;
    logic pc_valid, pc_first, pc_word_last, started;
    logic accept, word_last, disp_last, out_fire;

    census_word_popcount #(.CENSUS_W(CENSUS_W)) u_popcount (
        .left  (in_left),
        .right (in_right),
        .count (pc)
    );

    assign word_last = word_cnt == WC_W'(BLOCK_WORDS - 1);
    assign disp_last = disp_cnt == DISP_W'(NUM_DISP - 1);
    assign accept    = in_valid && in_ready && !flush;
    assign out_fire  = out_valid && out_ready;
    assign sum       = (pc_first ? '0 : acc) + COST_W'(pc_reg);
    assign busy      = state != RUN || started;
    assign out_disp  = best_disp;
    assign out_cost  = best_cost;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_nx;
    end

    // DRAIN waits until stage A has absorbed the final popcount.
    always_comb begin
        state_nx  = state;
        in_ready  = state == RUN;
        out_valid = state == HOLD;
        if (flush) state_nx = RUN;
        else if (state == RUN && accept && word_last && disp_last) state_nx = DRAIN;
        else if (state == DRAIN && !pc_valid) state_nx = HOLD;
        else if (state == HOLD && out_ready) state_nx = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            word_cnt     <= '0;
            disp_cnt     <= '0;
            pc_reg       <= '0;
            pc_valid     <= 1'b0;
            pc_first     <= 1'b0;
            pc_word_last <= 1'b0;
            pc_disp      <= '0;
            acc          <= '0;
            best_cost    <= '0;
            best_disp    <= '0;
            started      <= 1'b0;
        end else begin
            pc_valid <= accept;
            if (accept) begin
                pc_reg       <= pc;
                pc_first     <= word_cnt == '0;
                pc_word_last <= word_last;
                pc_disp      <= disp_cnt;
                word_cnt     <= word_last ? '0 : word_cnt + 1'b1;
                started      <= 1'b1;
                if (word_last) disp_cnt <= disp_last ? '0 : disp_cnt + 1'b1;
            end
            if (out_fire) begin
                word_cnt <= '0;
                disp_cnt <= '0;
                started  <= 1'b0;
            end
            // Strict compare keeps the lowest disparity on ties.
            if (pc_valid) begin
                acc <= sum;
                if (pc_word_last && (pc_disp == '0 || sum < best_cost)) begin
                    best_cost <= sum;
                    best_disp <= pc_disp;
                end
            end
        end
    end
endmodule

// File: tb/tb_census_cost_scheduler.sv
// tb_census_cost_scheduler: randomized scoreboard bench with a per-search reference model.
module tb_census_cost_scheduler;
    localparam int BW = 8;
    localparam int ND = 16;
    localparam int NB = BW * ND;

    typedef struct packed {
        logic [3:0] d;
        logic [7:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic in_ready, out_valid, busy;
    logic [3:0] out_disp;
    logic [7:0] out_cost;

    logic [15:0] lw [NB];
    logic [15:0] rw [NB];
    exp_t sb [$];
    exp_t mon_e;
    int checks = 0;
    int passes = 0;

    census_cost_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_left   (in_left),
        .in_right  (in_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_disp  (out_disp),
        .out_cost  (out_cost),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: per-disparity sum of bit differences, first minimum wins.
    function automatic exp_t model();
        exp_t e;
        int best = 0;
        int bd = 0;
        for (int d = 0; d < ND; d++) begin
            int cost = 0;
            for (int w = 0; w < BW; w++) cost += $countones(lw[d*BW+w] ^ rw[d*BW+w]);
            if (d == 0 || cost < best) begin
                best = cost;
                bd = d;
            end
        end
        e.d = 4'(bd);
        e.c = 8'(best);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got disp %0d cost %0d expected no result", out_disp, out_cost);
            end else begin
                mon_e = sb.pop_front();
                check("result_disp", out_disp, mon_e.d);
                check("result_cost", out_cost, mon_e.c);
            end
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int from, input int to, input int gap);
        for (int i = from; i <= to; i++) begin
            while ($urandom_range(99) < gap) idle();
            send(lw[i], rw[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) begin
            lw[i] = 16'($urandom);
            rw[i] = 16'($urandom);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            $display("FAIL wait_valid_timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL result_timeout: pending results got %0d expected 0", sb.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_disp"}, out_disp, 0);
        check({tag, "_out_cost"}, out_cost, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Clear winner at disparity 5 plus latency of the output
        for (int i = 0; i < NB; i++) begin
            lw[i] = (i / BW == 5) ? 16'hA5A5 : 16'($urandom);
            rw[i] = (i / BW == 5) ? 16'hA5A5 : ~lw[i];
        end
        sb.push_back(model());
        send_range(0, NB - 1, 0);
        @(negedge clk);
        check("lat_edge1_out_valid", out_valid, 0);
        check("lat_edge1_in_ready", in_ready, 0);
        @(negedge clk);
        check("lat_edge2_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_edge3_out_valid", out_valid, 1);
        check("winner_disp", out_disp, 5);
        check("winner_cost", out_cost, 0);
        wait_empty();

        // All ties
        for (int i = 0; i < NB; i++) begin
            lw[i] = 16'($urandom);
            rw[i] = lw[i] ^ 16'h000F;
        end
        sb.push_back(model());
        send_range(0, NB - 1, 0);
        wait_empty();

        // Max cost under backpressure
        for (int i = 0; i < NB; i++) begin
            lw[i] = 16'hFFFF;
            rw[i] = 16'h0000;
        end
        sb.push_back(model());
        out_ready = 1'b0;
        send_range(0, NB - 1, 0);
        wait_valid();
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_cost", out_cost, 128);
            check("bp_out_disp", out_disp, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_busy", busy, 0);
        check("post_hs_pending", sb.size(), 0);

        // Random data with idle gaps
        repeat (3) begin
            fill_random();
            sb.push_back(model());
            send_range(0, NB - 1, 30);
        end
        wait_empty();

        // Flush mid-search, then a clean search won by disparity 12
        fill_random();
        send_range(0, 36, 0);
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_out_cost", out_cost, 0);
        for (int i = 0; i < NB; i++) begin
            lw[i] = 16'($urandom);
            rw[i] = (i / BW == 12) ? ((i % BW == 0) ? lw[i] ^ 16'h0007 : lw[i]) : lw[i] ^ 16'h00FF;
        end
        sb.push_back(model());
        send_range(0, NB - 1, 10);
        @(negedge clk);
        @(negedge clk);
        check("flush_winner_disp", out_disp, 12);
        check("flush_winner_cost", out_cost, 3);
        wait_empty();

        // Asynchronous reset mid-block
        fill_random();
        send_range(0, 19, 0);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_mid");
        @(negedge clk);
        reset = 1'b0;
        fill_random();
        sb.push_back(model());
        send_range(0, NB - 1, 20);
        wait_empty();

        // Asynchronous reset while holding a result
        fill_random();
        sb.push_back(model());
        out_ready = 1'b0;
        send_range(0, NB - 1, 0);
        wait_valid();
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_hold");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        fill_random();
        sb.push_back(model());
        send_range(0, NB - 1, 30);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
